// File: rtl/seg_scan8_if.sv
// Display-word bus for seg_scan8: word/mask load on one side, the scanned digit
// outputs on the other.
interface seg_scan8_if;
    logic        load;
    logic [31:0] value;
    logic [7:0]  blank_mask;
    logic [3:0]  data;
    logic [7:0]  AN;
    logic        frame_start;
    logic        pending;

    modport master (
        output load, value, blank_mask,
        input  data, AN, frame_start, pending
    );

    modport slave (
        input  load, value, blank_mask,
        output data, AN, frame_start, pending
    );
endinterface

// File: rtl/seg_scan8.sv
// Eight-digit time-multiplexed hex scanner with frame-boundary double buffering.
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero suppression).
module seg_scan8 #(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned DEAD    = 16
) (
    input logic        clk,
    input logic        rst,
    seg_scan8_if.slave bus
);
    localparam int unsigned          CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shown_q, shown_d;
    logic [7:0]       shown_mask_q, shown_mask_d;
    logic [31:0]      pend_val_q, pend_val_d;
    logic [7:0]       pend_mask_q, pend_mask_d;
    logic             pending_q, pending_d;
    logic [7:0]       an_q, an_d;
    logic [3:0]       data_q, data_d;
    logic             fs_q, fs_d;

    logic boundary;
    logic in_dead;
    logic lz_dark;

    // NOTE: combinational blocks assign every output a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shown_d      = shown_q;
        shown_mask_d = shown_mask_q;
        pend_val_d   = pend_val_q;
        pend_mask_d  = pend_mask_q;
        pending_d    = pending_q;
        boundary     = (cnt_q == CNT_LAST) && (idx_q == 3'd7);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        if (bus.load) begin
            pend_val_d  = bus.value;
            pend_mask_d = bus.blank_mask;
            pending_d   = 1'b1;
        end

        // A load coinciding with the boundary goes straight to the display.
        if (boundary) begin
            if (bus.load) begin
                shown_d      = bus.value;
                shown_mask_d = bus.blank_mask;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                shown_d      = pend_val_q;
                shown_mask_d = pend_mask_q;
                pending_d    = 1'b0;
            end
        end
    end

    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt_d < CNT_W'(DEAD));
        end
    endgenerate

`ifdef SEG_LZ_BLANK_EN
    assign lz_dark = (idx_d != 3'd0) && ((shown_d >> {idx_d, 2'b00}) == 32'd0);
`else
    assign lz_dark = 1'b0;
`endif

    // Outputs are registered from the state being entered, so they line up with idx_q/cnt_q.
    always_comb begin
        data_d = shown_d[{idx_d, 2'b00} +: 4];
        fs_d   = boundary;
        if (in_dead || shown_mask_d[idx_d] || lz_dark) begin
            an_d = 8'hFF;
        end else begin
            an_d = ~(8'b1 << idx_d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shown_q      <= '0;
            shown_mask_q <= '0;
            pend_val_q   <= '0;
            pend_mask_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= 8'hFF;
            data_q       <= 4'h0;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            shown_mask_q <= shown_mask_d;
            pend_val_q   <= pend_val_d;
            pend_mask_q  <= pend_mask_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            data_q       <= data_d;
            fs_q         <= fs_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.data        = data_q;
    assign bus.frame_start = fs_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_seg_scan8.sv
// Directed bench for seg_scan8 (CLK_DIV = 8, DEAD = 2): scan pattern, buffered loads,
// boundary bypass, blanking, leading-zero option and mid-frame reset.
module tb_seg_scan8;
    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;

    logic clk = 1'b0;
    logic rst;

    seg_scan8_if bus ();

    seg_scan8 #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] shown_tab [6];
    logic [7:0]  lit_tab   [6];

    task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // local_c is the position within the scan since the last reset.
    task automatic chk_slot(input int cyc, input int local_c, input logic [31:0] word,
                            input logic [7:0] lit, input logic pend_exp, input logic fs_exp);
        int         i;
        int         k;
        logic [7:0] exp_an;
        i = (local_c / 8) % 8;
        k = local_c % 8;
        exp_an = (k < DEAD || !lit[i]) ? 8'hFF : ~(8'b1 << i);
        chk("AN", cyc, bus.AN, exp_an);
        chk("data", cyc, bus.data, word[4*i +: 4]);
        chk("frame_start", cyc, bus.frame_start, fs_exp);
        chk("pending", cyc, bus.pending, pend_exp);
    endtask

    task automatic drive_load(input logic [31:0] v, input logic [7:0] m);
        bus.load       = 1'b1;
        bus.value      = v;
        bus.blank_mask = m;
    endtask

    initial begin
        int   f;
        logic pend_exp;

        shown_tab = '{32'h0000_0000, 32'h89AB_CDEF, 32'h1234_5678,
                      32'h2222_2222, 32'hFFFF_FFFF, 32'h0000_0A05};
        lit_tab   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'hFF};
`ifdef SEG_LZ_BLANK_EN
        lit_tab[5] = 8'h07;
`endif

        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cycle 0 is the first cycle after the reset edge (state idx=0, cnt=0).
        for (int c = 0; c < 356; c++) begin
            f = c / 64;
            pend_exp = (c >= 21  && c <= 63)  || (c >= 131 && c <= 191) ||
                       (c >= 201 && c <= 255) || (c >= 261 && c <= 319) || (c == 355);
            chk_slot(c, c, shown_tab[f], lit_tab[f], pend_exp, (c % 64 == 0) && (c != 0));

            bus.load = 1'b0;
            case (c)
                20:  drive_load(32'h89AB_CDEF, 8'h00);
                127: drive_load(32'h1234_5678, 8'h00);
                130: drive_load(32'h1111_1111, 8'h00);
                140: drive_load(32'h2222_2222, 8'h00);
                200: drive_load(32'hFFFF_FFFF, 8'h81);
                260: drive_load(32'h0000_0A05, 8'h00);
                354: drive_load(32'hCAFE_F00D, 8'h00);
                355: rst = 1'b1;
                default: ;
            endcase
            @(posedge clk);
            #1;
        end

        // Cycle 356: reset taken at idx = 4; the waiting word is discarded.
        chk("rst_AN", 356, bus.AN, 8'hFF);
        chk("rst_data", 356, bus.data, 4'h0);
        chk("rst_pending", 356, bus.pending, 1'b0);
        chk("rst_frame_start", 356, bus.frame_start, 1'b0);

        // A load while reset is held must be ignored.
        drive_load(32'hDEAD_BEEF, 8'hFF);
        @(posedge clk);
        #1;

        for (int c2 = 0; c2 < 72; c2++) begin
            chk_slot(357 + c2, c2, 32'h0, 8'hFF, 1'b0, c2 == 64);
            if (c2 == 0) begin
                rst      = 1'b0;
                bus.load = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
